// File: rtl/trng_pkg.sv
// Shared types for the TRNG collector: FSM states and health-counter width.
package trng_pkg;
  typedef enum logic [1:0] {IDLE, WARMUP, RUN, FAIL} trng_state_t;
  localparam int REP_CNT_W = 8;
endpackage

// File: rtl/trng_vn_debias.sv
// Von Neumann corrector: pairs samples (a,b); 10 emits 1, 01 emits 0, 00/11 emit nothing.
module trng_vn_debias (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic in_valid,
  input  logic in_bit,
  output logic out_valid,
  output logic out_bit
);
  logic phase, a_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 1'b0;
      a_bit <= 1'b0;
    end else if (clear) begin
      phase <= 1'b0;
      a_bit <= 1'b0;
    end else if (in_valid) begin
      phase <= ~phase;
      if (!phase) a_bit <= in_bit;
    end
  end

  // The emitted bit equals the first sample of an unequal pair.
  assign out_valid = in_valid && phase && (a_bit != in_bit);
  assign out_bit   = a_bit;
endmodule

// File: rtl/trng_collector.sv
// TRNG consumer: warm-up gating, von Neumann debias, word packing with valid/ready,
// and a sticky repetition-count health test on the synchronized raw stream.
module trng_collector import trng_pkg::*; #(
  parameter int WIDTH     = 32,
  parameter int WARMUP    = 1024,
  parameter int REP_LIMIT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             trng_en,
  input  logic             trng_out,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             health_fail,
  output logic             overflow
);
  localparam int BCW = $clog2(WIDTH + 1);
  localparam int WCW = $clog2(WARMUP + 1);

  trng_state_t          state, state_nxt;
  logic                 s1, s2, raw_last;
  logic [WCW-1:0]       warm_cnt;
  logic [REP_CNT_W-1:0] rep_cnt, rep_nxt;
  logic [BCW-1:0]       bit_cnt;
  logic [WIDTH-2:0]     shreg;
  logic [WIDTH-1:0]     word_nxt;
  logic                 run, warm_done, health_trip, vn_valid, vn_bit, take, word_done;

  assign run       = (state == trng_pkg::RUN);
  assign warm_done = (warm_cnt == WCW'(WARMUP - 1));
  assign trng_en   = (state == trng_pkg::WARMUP) || run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= trng_out;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= trng_pkg::IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      trng_pkg::IDLE:   if (en) state_nxt = trng_pkg::WARMUP;
      trng_pkg::WARMUP: if (warm_done) state_nxt = trng_pkg::RUN;
      trng_pkg::RUN:    if (health_trip) state_nxt = trng_pkg::FAIL;
      default:          state_nxt = state;
    endcase
    if (!en) state_nxt = trng_pkg::IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          warm_cnt <= '0;
    else if (state == trng_pkg::WARMUP)  warm_cnt <= warm_cnt + 1'b1;
    else                                 warm_cnt <= '0;
  end

  // A zero count marks the first RUN sample, which always starts a fresh run of 1.
  always_comb begin
    rep_nxt = REP_CNT_W'(1);
    if (rep_cnt != '0 && s2 == raw_last)
      rep_nxt = (rep_cnt == '1) ? rep_cnt : rep_cnt + 1'b1;
  end
  assign health_trip = run && (rep_nxt == REP_CNT_W'(REP_LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt  <= '0;
      raw_last <= 1'b0;
    end else begin
      rep_cnt  <= run ? rep_nxt : '0;
      raw_last <= s2;
    end
  end

  trng_vn_debias u_vn (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (!run || !en),
    .in_valid (run),
    .in_bit   (s2),
    .out_valid(vn_valid),
    .out_bit  (vn_bit)
  );

  // A health trip in the same cycle discards the incoming bit, so no word can complete.
  assign take      = run && en && vn_valid && !health_trip;
  assign word_done = take && (bit_cnt == BCW'(WIDTH - 1));
  assign word_nxt  = {shreg, vn_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (!en) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (take) begin
      shreg   <= word_nxt[WIDTH-2:0];
      bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data        <= '0;
      valid       <= 1'b0;
      overflow    <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      if (word_done && (!valid || ready)) begin
        data  <= word_nxt;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      if (!en)                                  overflow <= 1'b0;
      else if (word_done && valid && !ready)    overflow <= 1'b1;
      if (!en)              health_fail <= 1'b0;
      else if (health_trip) health_fail <= 1'b1;
    end
  end
endmodule

// File: tb/tb_trng_collector.sv
// Directed bench for trng_collector with WIDTH=8, WARMUP=4, REP_LIMIT=8.
module tb_trng_collector;
  localparam int WIDTH = 8;
  localparam int WARM  = 4;
  localparam int REPL  = 8;

  logic             clk = 1'b0;
  logic             rst_n, en, trng_out, ready;
  logic             trng_en, valid, health_fail, overflow;
  logic [WIDTH-1:0] data;

  int checks = 0;
  int errors = 0;
  int idle_idx = 0;

  trng_collector #(.WIDTH(WIDTH), .WARMUP(WARM), .REP_LIMIT(REPL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .trng_en    (trng_en),
    .trng_out   (trng_out),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .health_fail(health_fail),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One raw sample per cycle, changed on the falling edge.
  task automatic drive_bit(input logic b);
    trng_out = b;
    @(negedge clk);
  endtask

  // Pairs 00/11 only, so no corrected bits; always called in even counts to keep pair alignment.
  task automatic idle();
    logic [31:0] v;
    v = idle_idx;
    drive_bit(v[1]);
    idle_idx++;
  endtask

  task automatic stream(input logic [63:0] pat, input int len, input int reps);
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < len; i++) drive_bit(pat[len-1-i]);
  endtask

  // Raise en and pre-drive so the next streamed bit is the first RUN sample.
  task automatic start_run(input logic pre);
    en = 1'b1;
    for (int i = 0; i < WARM - 1; i++) drive_bit(pre);
    idle_idx = 0;
  endtask

  task automatic stop_run();
    en = 1'b0;
    drive_bit(1'b0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; trng_out = 1'b0; ready = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_trng_en", trng_en, 0);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_health", health_fail, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    drive_bit(1'b0); drive_bit(1'b0);

    // Constant 1: the 8th RUN sample trips the health test.
    start_run(1'b1);
    chk("t1_trng_en_warm", trng_en, 1);
    stream(64'h1, 1, 8);
    drive_bit(1'b1);
    chk("t1_health_before", health_fail, 0);
    drive_bit(1'b1);
    chk("t1_health_fail", health_fail, 1);
    chk("t1_trng_en_off", trng_en, 0);
    chk("t1_valid", valid, 0);
    stop_run();
    chk("t1_en_clears_health", health_fail, 0);
    drive_bit(1'b0);

    // 10,01 repeated -> AA after 16 samples, 3-cycle latency.
    start_run(1'b0);
    stream(64'h9, 4, 4);
    idle();
    chk("t2_latency_not_yet", valid, 0);
    idle();
    chk("t2_valid", valid, 1);
    chk("t2_data", data, 8'hAA);
    ready = 1'b1; idle(); ready = 1'b0;
    chk("t2_consumed", valid, 0);
    idle();

    // 00 and 11 pairs interleaved with 10 pairs -> only 10s count.
    stream(64'h8B, 8, 4);
    idle(); idle();
    chk("t3_valid", valid, 1);
    chk("t3_data", data, 8'hFF);

    // Word completes in the same cycle the held word is taken.
    stream(64'h6, 4, 4);
    idle();
    ready = 1'b1; idle(); ready = 1'b0;
    chk("t3b_valid_kept", valid, 1);
    chk("t3b_new_data", data, 8'h55);
    chk("t3b_no_overflow", overflow, 0);
    ready = 1'b1; idle(); ready = 1'b0; idle();
    chk("t3b_consumed", valid, 0);

    // Two words with ready low: first held, second dropped.
    stream(64'h9, 4, 4);
    stream(64'h6, 4, 4);
    idle(); idle();
    chk("t4_overflow", overflow, 1);
    chk("t4_valid", valid, 1);
    chk("t4_first_kept", data, 8'hAA);

    // Five bits packed, then en dropped: partial word discarded, held word kept.
    stream(64'h2, 2, 5);
    idle(); idle();
    stop_run();
    chk("t5_trng_en_off", trng_en, 0);
    chk("t5_overflow_cleared", overflow, 0);
    chk("t5_valid_kept", valid, 1);
    chk("t5_data_kept", data, 8'hAA);
    ready = 1'b1; drive_bit(1'b0); ready = 1'b0;
    chk("t4_consumed", valid, 0);
    start_run(1'b0);
    chk("t5_warmup_again", trng_en, 1);
    chk("t5_no_early_word", valid, 0);
    stream(64'h6, 4, 4);
    idle();
    chk("t5_latency_not_yet", valid, 0);
    idle();
    chk("t5_valid", valid, 1);
    chk("t5_no_stale_bits", data, 8'h55);

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", valid, 0);
    chk("t6_async_data", data, 0);
    chk("t6_async_trng_en", trng_en, 0);
    chk("t6_async_overflow", overflow, 0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_after_release", valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
